// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between execute and fetch
// Execute has priority; fetch wins once it has been denied STARVE_MAX cycles in a row.
module mem_port_arbiter #(
   parameter int STARVE_MAX = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ex_req,
   input  logic       ex_we,
   input  logic [7:0] ex_addr,
   input  logic [7:0] ex_wdata,
   output logic       ex_gnt,
   output logic       ex_rvalid,
   input  logic       f_req,
   input  logic [7:0] f_addr,
   output logic       f_gnt,
   output logic       f_rvalid,
   output logic [7:0] rdata,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_wren,
   output logic       mem_rden,
   input  logic [7:0] mem_q,
   output logic       fetch_stall
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_EX   = 2'd1,
      OWN_F    = 2'd2
   } owner_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   owner_t     owner_q, owner_d;
   logic [3:0] starve_q, starve_d;
   logic       starved;

   always_ff @(posedge clock) begin
      if (reset) begin
         owner_q  <= OWN_NONE;
         starve_q <= 4'd0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      starved   = (starve_q == STARVE_LIM);
      f_gnt     = f_req & (~ex_req | starved);
      ex_gnt    = ex_req & ~f_gnt;
      mem_wren  = ex_gnt & ex_we;
      mem_rden  = f_gnt | (ex_gnt & ~ex_we);
      mem_addr  = ex_gnt ? ex_addr : f_addr;
      mem_wdata = ex_gnt ? ex_wdata : 8'd0;
      fetch_stall = f_req & ~f_gnt;

      starve_d = starve_q;
      if (!f_req || f_gnt) begin
         starve_d = 4'd0;
      end else if (starve_q < STARVE_LIM) begin
         starve_d = starve_q + 4'd1;
      end

      owner_d = OWN_NONE;
      if (f_gnt) begin
         owner_d = OWN_F;
      end else if (ex_gnt && !ex_we) begin
         owner_d = OWN_EX;
      end

      // Gating with reset kills a pending rvalid when reset lands right after an issue.
      ex_rvalid = ~reset & (owner_q == OWN_EX);
      f_rvalid  = ~reset & (owner_q == OWN_F);
      rdata     = mem_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic       clock;
   logic       reset;
   logic       ex_req, ex_we;
   logic [7:0] ex_addr, ex_wdata;
   logic       ex_gnt, ex_rvalid;
   logic       f_req;
   logic [7:0] f_addr;
   logic       f_gnt, f_rvalid;
   logic [7:0] rdata, mem_addr, mem_wdata, mem_q;
   logic       mem_wren, mem_rden, fetch_stall;

   int checks;
   int failures;

   mem_port_arbiter #(.STARVE_MAX(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .ex_req     (ex_req),
      .ex_we      (ex_we),
      .ex_addr    (ex_addr),
      .ex_wdata   (ex_wdata),
      .ex_gnt     (ex_gnt),
      .ex_rvalid  (ex_rvalid),
      .f_req      (f_req),
      .f_addr     (f_addr),
      .f_gnt      (f_gnt),
      .f_rvalid   (f_rvalid),
      .rdata      (rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wren   (mem_wren),
      .mem_rden   (mem_rden),
      .mem_q      (mem_q),
      .fetch_stall(fetch_stall)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_exg"}, {7'd0, ex_gnt}, 8'd0);
      chk({tag, "_fg"}, {7'd0, f_gnt}, 8'd0);
      chk({tag, "_wren"}, {7'd0, mem_wren}, 8'd0);
      chk({tag, "_rden"}, {7'd0, mem_rden}, 8'd0);
      chk({tag, "_exrv"}, {7'd0, ex_rvalid}, 8'd0);
      chk({tag, "_frv"}, {7'd0, f_rvalid}, 8'd0);
      chk({tag, "_stall"}, {7'd0, fetch_stall}, 8'd0);
   endtask

   initial begin
      logic [4:0] exp_ex;
      logic [4:0] exp_f;
      logic [3:0] exp_ex2;
      logic [3:0] exp_f2;
      checks   = 0;
      failures = 0;
      reset = 1'b1;
      ex_req = 1'b0; ex_we = 1'b0; ex_addr = 8'h00; ex_wdata = 8'h00;
      f_req = 1'b0; f_addr = 8'h00; mem_q = 8'h00;
      tick();
      tick();
      idle_chk("rst");

      // lone fetch read
      reset = 1'b0;
      tick();
      f_req = 1'b1; f_addr = 8'h05;
      #1;
      chk("f_gnt", {7'd0, f_gnt}, 8'd1);
      chk("f_exg", {7'd0, ex_gnt}, 8'd0);
      chk("f_rden", {7'd0, mem_rden}, 8'd1);
      chk("f_addr", mem_addr, 8'h05);
      chk("f_stall", {7'd0, fetch_stall}, 8'd0);
      tick();
      f_req = 1'b0; mem_q = 8'h3C;
      #1;
      chk("f_rv", {7'd0, f_rvalid}, 8'd1);
      chk("f_exrv", {7'd0, ex_rvalid}, 8'd0);
      chk("f_rdata", rdata, 8'h3C);
      tick();
      chk("f_rv_end", {7'd0, f_rvalid}, 8'd0);

      // execute write versus fetch
      ex_req = 1'b1; ex_we = 1'b1; ex_addr = 8'h20; ex_wdata = 8'hA5;
      f_req = 1'b1; f_addr = 8'h30;
      #1;
      chk("w_exg", {7'd0, ex_gnt}, 8'd1);
      chk("w_fg", {7'd0, f_gnt}, 8'd0);
      chk("w_wren", {7'd0, mem_wren}, 8'd1);
      chk("w_rden", {7'd0, mem_rden}, 8'd0);
      chk("w_addr", mem_addr, 8'h20);
      chk("w_wdata", mem_wdata, 8'hA5);
      chk("w_stall", {7'd0, fetch_stall}, 8'd1);
      tick();
      ex_req = 1'b0; ex_we = 1'b0; f_req = 1'b0;
      #1;
      chk("w_exrv", {7'd0, ex_rvalid}, 8'd0);
      chk("w_frv", {7'd0, f_rvalid}, 8'd0);
      tick();

      // starvation: both held, fetch wins on cycle 3
      exp_ex = 5'b10111;
      exp_f  = 5'b01000;
      ex_req = 1'b1; ex_we = 1'b0; ex_addr = 8'h40;
      f_req = 1'b1; f_addr = 8'h50;
      #1;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("st_exg%0d", c), {7'd0, ex_gnt}, {7'd0, exp_ex[c]});
         chk($sformatf("st_fg%0d", c), {7'd0, f_gnt}, {7'd0, exp_f[c]});
         chk($sformatf("st_addr%0d", c), mem_addr, exp_f[c] ? 8'h50 : 8'h40);
         if (c > 0) begin
            chk($sformatf("st_exrv%0d", c), {7'd0, ex_rvalid}, {7'd0, exp_ex[c-1]});
            chk($sformatf("st_frv%0d", c), {7'd0, f_rvalid}, {7'd0, exp_f[c-1]});
         end
         tick();
      end
      ex_req = 1'b0; f_req = 1'b0;
      #1;
      chk("st_exrv5", {7'd0, ex_rvalid}, 8'd1);
      tick();

      // back-to-back EX read then F read
      ex_req = 1'b1; ex_we = 1'b0; ex_addr = 8'h10;
      #1;
      chk("bb_exg", {7'd0, ex_gnt}, 8'd1);
      chk("bb_addr0", mem_addr, 8'h10);
      tick();
      ex_req = 1'b0; f_req = 1'b1; f_addr = 8'h11; mem_q = 8'h77;
      #1;
      chk("bb_fg", {7'd0, f_gnt}, 8'd1);
      chk("bb_addr1", mem_addr, 8'h11);
      chk("bb_exrv", {7'd0, ex_rvalid}, 8'd1);
      chk("bb_frv0", {7'd0, f_rvalid}, 8'd0);
      chk("bb_rdata0", rdata, 8'h77);
      tick();
      f_req = 1'b0; mem_q = 8'h88;
      #1;
      chk("bb_frv", {7'd0, f_rvalid}, 8'd1);
      chk("bb_exrv1", {7'd0, ex_rvalid}, 8'd0);
      chk("bb_rdata1", rdata, 8'h88);
      tick();
      chk("bb_frv_end", {7'd0, f_rvalid}, 8'd0);

      // reset right after a fetch read issue
      f_req = 1'b1; f_addr = 8'h22;
      #1;
      chk("rs_fg", {7'd0, f_gnt}, 8'd1);
      tick();
      reset = 1'b1;
      ex_req = 1'b1; ex_we = 1'b0; ex_addr = 8'h60;
      f_req = 1'b1; f_addr = 8'h70;
      #1;
      chk("rs_frv_in", {7'd0, f_rvalid}, 8'd0);
      chk("rs_exrv_in", {7'd0, ex_rvalid}, 8'd0);
      tick();
      chk("rs_frv_in2", {7'd0, f_rvalid}, 8'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("rs_frv_out", {7'd0, f_rvalid}, 8'd0);
      chk("rs_exrv_out", {7'd0, ex_rvalid}, 8'd0);
      exp_ex2 = 4'b0111;
      exp_f2  = 4'b1000;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("rs_exg%0d", c), {7'd0, ex_gnt}, {7'd0, exp_ex2[c]});
         chk($sformatf("rs_fg%0d", c), {7'd0, f_gnt}, {7'd0, exp_f2[c]});
         tick();
      end
      ex_req = 1'b0; f_req = 1'b0;
      tick();
      tick();

      // idle cycles
      f_addr = 8'h99;
      for (int c = 0; c < 4; c++) begin
         #1;
         idle_chk($sformatf("idle%0d", c));
         chk($sformatf("idle_addr%0d", c), mem_addr, 8'h99);
         chk($sformatf("idle_wdata%0d", c), mem_wdata, 8'h00);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3, sets the number of consecutive denied fetch cycles after which fetch wins priority; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ex_req  input  1  execute stage requests a data-memory access this cycle.
REQ-005 ex_we  input  1  1 = write, 0 = read; qualified by ex_req.
REQ-006 ex_addr  input  8  execute access address.
REQ-007 ex_wdata  input  8  execute write data.
REQ-008 ex_gnt  output  1  execute access is issued this cycle (combinational).
REQ-009 ex_rvalid  output  1  execute read data valid this cycle.
REQ-010 f_req  input  1  fetch stage requests an instruction read.
REQ-011 f_addr  input  8  fetch address (PC).
REQ-012 f_gnt  output  1  fetch read is issued this cycle (combinational).
REQ-013 f_rvalid  output  1  fetch read data valid this cycle.
REQ-014 rdata  output  8  read data; mem_q passed through, meaningful only when ex_rvalid or f_rvalid is high.
REQ-015 mem_addr  output  8  address to the single-port memory.
REQ-016 mem_wdata  output  8  write data to the memory.
REQ-017 mem_wren  output  1  memory write enable.
REQ-018 mem_rden  output  1  memory read enable.
REQ-019 mem_q  input  8  memory read data, valid exactly 1 cycle after the read issue.
REQ-020 fetch_stall  output  1  high when f_req is high and f_gnt is low; used to hold the PC and IR1.

Function
REQ-021 At most one of ex_gnt or f_gnt shall be high in any cycle, and a grant shall be given only to an active requester.
REQ-022 Default priority: execute over fetch; a lone requester shall always be granted in the same cycle.
REQ-023 A 4-bit starve counter shall increment, saturating at STARVE_MAX, on each cycle with f_req=1 and f_gnt=0.
REQ-024 The starve counter shall clear on any cycle with f_gnt=1 or f_req=0.
REQ-025 When the starve counter equals STARVE_MAX and both requesters are active, fetch shall be granted and execute denied for that cycle.
REQ-026 mem_addr/mem_wdata shall follow the granted requester; with no grant, mem_addr = f_addr, mem_wdata = 0, mem_wren = 0, mem_rden = 0.
REQ-027 mem_wren = ex_gnt & ex_we.
REQ-028 mem_rden = f_gnt | (ex_gnt & ~ex_we).
REQ-029 A registered 2-bit owner tag shall record the issuer of each read: NONE, EX or F.
REQ-030 In the cycle after a read issue, exactly the matching rvalid shall be high for one cycle; writes shall produce no rvalid.
REQ-031 Reads may issue on consecutive cycles (throughput 1/cycle); each rvalid shall correspond to the issue exactly one cycle earlier.
REQ-032 A denied requester shall hold req and its address stable until granted; the arbiter keeps no request queue.
REQ-033 ex_req with ex_we=1 and f_req at the same time is a normal conflict, arbitrated per REQ-022/REQ-025.

Reset
REQ-034 While reset=1: owner tag = NONE, starve counter = 0, ex_rvalid = 0, f_rvalid = 0; grants remain combinational but the registered state is held at reset values.
REQ-035 If reset asserts in the cycle after a read issue, the pending rvalid shall be suppressed; no rvalid shall appear in the first cycle after reset deasserts.

Verification
REQ-036 f_req=1, f_addr=0x05, ex_req=0 -> f_gnt=1, mem_rden=1, mem_addr=0x05; next cycle f_rvalid=1, rdata=mem_q.
REQ-037 ex_req=1, ex_we=1, ex_addr=0x20, ex_wdata=0xA5, and f_req=1 -> ex_gnt=1, mem_wren=1, mem_addr=0x20, fetch_stall=1; next cycle no rvalid.
REQ-038 STARVE_MAX=3, ex_req and f_req both held high -> ex_gnt for cycles 0-2, f_gnt in cycle 3, ex_gnt in cycle 4; the counter restarts from 0.
REQ-039 Alternating EX read 0x10 then F read 0x11 on back-to-back cycles -> ex_rvalid then f_rvalid on the following two cycles, never both high.
REQ-040 F read issued and reset=1 on the next cycle -> f_rvalid=0 during and after reset; starve counter = 0.
REQ-041 No requests for 4 cycles -> all grants, mem_wren, mem_rden and rvalids low; fetch_stall=0.
